// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the 64x32 instruction ROM and hands words to decode over valid/ready.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch_count / stall_count outputs.
module instruction_fetch_unit #(
  parameter int                 ADDR_W    = 6,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, instr_pc_d;
  logic [DATA_W-1:0] instr_out_d;
  logic              instr_valid_d;
  logic              slot_free, fetch_ok, capture, halt_hit, stall;

  assign rom_address = pc;
  assign halted      = (state == HALT);
  assign slot_free   = !instr_valid || instr_ready;
  assign fetch_ok    = (state == FETCH) && en && !branch_valid && slot_free;
  assign capture     = fetch_ok && (rom_data != HALT_WORD);
  assign halt_hit    = fetch_ok && (rom_data == HALT_WORD);
  assign stall       = (state == FETCH) && instr_valid && !instr_ready;

  // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    instr_out_d   = instr_out;
    instr_pc_d    = instr_pc;
    // An accepted word leaves the register unless a new capture refills it.
    instr_valid_d = instr_valid && !instr_ready;

    if (branch_valid) begin
      // Redirect wins over everything; the pending word is flushed.
      pc_d          = branch_target;
      instr_valid_d = 1'b0;
      state_d       = en ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en) state_d = FETCH;
        end
        FETCH: begin
          if (!en) begin
            state_d = IDLE;
          end else if (capture) begin
            instr_out_d   = rom_data;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
            pc_d          = pc + ADDR_W'(1);
          end else if (halt_hit) begin
            // Halt word is never delivered; pc parks on it.
            state_d = HALT;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instr_out   <= instr_out_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= instr_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Counters saturate and survive branches; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (capture && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
      if (stall && (stall_count != 16'hFFFF))   stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Reader side of the 64x32 instruction ROM interface.
- Owns the program counter and drives the ROM address. Samples the combinational ROM data word and hands instructions to the decode stage over a valid/ready handshake.
- Supports branch redirect, a halt instruction and PC wrap-around.
- Sits between the instruction ROM and the decoder in the 8-bit Harvard core.

Parameters:
- ADDR_W, 6, ROM address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  fetch enable; low pauses fetching.
- rom_address  output  ADDR_W  address to instruction ROM, equal to current PC.
- rom_data  input  DATA_W  combinational ROM read data for rom_address.
- branch_valid  input  1  redirect request, single-cycle pulse or level.
- branch_target  input  ADDR_W  new PC when branch_valid is high.
- instr_out  output  DATA_W  registered instruction to decoder.
- instr_pc  output  ADDR_W  address from which instr_out was fetched.
- instr_valid  output  1  instr_out/instr_pc valid.
- instr_ready  input  1  decoder accepts instruction when valid && ready.
- halted  output  1  high while FSM is in HALT.

Behaviour:
- Reset (rst_n=0 at clk edge): pc=RESET_PC, state=IDLE, instr_valid=0, instr_out=0, instr_pc=0, halted=0. Reset takes effect mid-operation and drops any pending instruction.
- rom_address = pc, combinational from the PC register.
- slot_free = !instr_valid || instr_ready.
- FSM states:
  - IDLE: entered after reset. Goes to FETCH when en=1.
  - FETCH: fetches each cycle permitted by the capture rule. Goes to IDLE when en=0; the output register holds its contents until accepted.
  - HALT: no fetch, halted=1, pc frozen. Exits only on branch_valid (to FETCH if en=1, else IDLE) or on reset.
- Capture, in FETCH with en=1, no branch, slot_free=1:
  - If rom_data != HALT_WORD: instr_out<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1 modulo 2^ADDR_W (63 -> 0, no error).
  - If rom_data == HALT_WORD: the word is not delivered. The instruction in the output register, if any, completes normally. state<=HALT; pc stays at the halt address.
- Stall: FETCH with instr_valid=1 and instr_ready=0. No capture; pc, instr_out and instr_pc hold.
- Handshake: instr_out and instr_pc are stable while instr_valid=1 && instr_ready=0. Each instruction is accepted exactly once. Throughput is one instruction per cycle when instr_ready is held high.
- Latency: the instruction at address A appears on instr_out 1 cycle after pc=A in FETCH with slot_free.
- Branch (branch_valid=1, any state except reset):
  - pc<=branch_target and instr_valid<=0; the flush discards the unaccepted instruction.
  - No capture occurs that cycle.
  - Branch has priority over capture, halt detection and stall.
  - The first post-branch instruction (from branch_target) appears 2 cycles after the branch cycle, given en=1 and ready.
- A simultaneous branch and instr_ready=1 on a valid instruction counts as accepted by the decoder. The register is still cleared.
- en=0 does not clear instr_valid; the decoder may still drain it.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_count[15:0] and stall_count[15:0], both reset to 0.
  - fetch_count increments on each delivered capture.
  - stall_count increments each cycle spent in FETCH with instr_valid=1 && instr_ready=0.
  - Both counters saturate at 16'hFFFF and are not cleared by branch.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Bench ROM returns data=address. Hold en=1 and instr_ready=1 after reset -> instr_out/instr_pc = 0,1,2,... on consecutive cycles, instr_valid continuously high from the second cycle.
- Free-run past address 63 -> instr_pc sequence ...62,63,0,1 with no bubble and data matching.
- Hold instr_ready=0 for 5 cycles while instr_pc=4 -> instr_out=4 held, rom_address=5 held. Release -> 5 delivered next. With FETCH_PERF_CNT_EN, stall_count=5.
- Pulse branch_valid with branch_target=40 while instr_pc=10 is valid and unaccepted -> instr_valid=0 next cycle; next delivered instr_pc=40, data=40, 2 cycles after the branch.
- Override ROM word 7 to HALT_WORD -> instructions 0..6 delivered, 7 never delivered, halted=1, rom_address stays 7. Branch to 20 -> halted=0 and fetch resumes at 20.
- Assert rst_n=0 for one cycle mid-stream at instr_pc=30 -> next edge: instr_valid=0, pc=0, state IDLE. Fetch restarts at 0 with en=1.
